// File: rtl/multiword_add_seq_pkg.sv
// Shared types and helpers for the chunked multi-word adder sequencer.
package multiword_add_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        ADD  = 2'b01,
        DONE = 2'b10
    } state_t;

    function automatic int cnt_w(input int words);
        return $clog2(words);
    endfunction

endpackage

// File: rtl/cnt_adder.sv
// N-bit ripple-carry adder; the only arithmetic resource of the sequencer.
module cnt_adder #(
    parameter int N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] s,
    output logic         cout
);

    always_comb begin
        logic [N:0] c;
        c    = '0;
        c[0] = cin;
        s    = '0;
        for (int i = 0; i < N; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
        end
        cout = c[N];
    end

endmodule

// File: rtl/multiword_add_seq.sv
// Adds two WORDS*N-bit operands one N-bit chunk per cycle, LSB chunk first.
// Optional MULTIWORD_ADD_SEQ_SUB_EN adds a sub port for A-B.
//
// state | meaning
// IDLE  | waiting for start; s/cout hold the last result
// ADD   | one chunk per edge, counter k selects the s slice
// DONE  | one-cycle done pulse, start ignored
module multiword_add_seq
    import multiword_add_seq_pkg::*;
#(
    parameter int N     = 8,
    parameter int WORDS = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [WORDS*N-1:0] a,
    input  logic [WORDS*N-1:0] b,
    input  logic               cin,
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    input  logic               sub,
`endif
    output logic               busy,
    output logic               done,
    output logic [WORDS*N-1:0] s,
    output logic               cout
);

    localparam int W  = WORDS * N;
    localparam int CW = cnt_w(WORDS);
    localparam logic [CW-1:0] K_LAST = CW'(WORDS - 1);

    state_t        state;
    logic [W-1:0]  a_sr;
    logic [W-1:0]  b_sr;
    logic          carry;
    logic [CW-1:0] k;

    logic [N-1:0]  b_chunk;
    logic [N-1:0]  sum_chunk;
    logic          add_cout;
    logic          init_carry;

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    logic sub_r;

    // Two's-complement subtract: invert B per chunk, seed carry with 1.
    assign b_chunk    = b_sr[N-1:0] ^ {N{sub_r}};
    assign init_carry = sub ? 1'b1 : cin;
`else
    assign b_chunk    = b_sr[N-1:0];
    assign init_carry = cin;
`endif

    cnt_adder #(.N(N)) u_adder (
        .a    (a_sr[N-1:0]),
        .b    (b_chunk),
        .cin  (carry),
        .s    (sum_chunk),
        .cout (add_cout)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            a_sr  <= '0;
            b_sr  <= '0;
            carry <= 1'b0;
            k     <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            s     <= '0;
            cout  <= 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
            sub_r <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= init_carry;
                        k     <= '0;
                        busy  <= 1'b1;
                        state <= ADD;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
                        sub_r <= sub;
`endif
                    end
                end
                ADD: begin
                    s[int'(k)*N +: N] <= sum_chunk;
                    carry <= add_cout;
                    a_sr  <= a_sr >> N;
                    b_sr  <= b_sr >> N;
                    if (k == K_LAST) begin
                        k     <= '0;
                        cout  <= add_cout;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        k <= k + 1'b1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// Directed self-checking bench for multiword_add_seq (N=8, WORDS=4).
module tb_multiword_add_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
    logic        sub;
`endif
    logic        busy;
    logic        done;
    logic [31:0] s;
    logic        cout;

    int checks   = 0;
    int failures = 0;

    multiword_add_seq #(.N(8), .WORDS(4)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        .sub   (sub),
`endif
        .busy  (busy),
        .done  (done),
        .s     (s),
        .cout  (cout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive start for exactly one rising edge, launched from a negedge.
    task automatic do_start(input logic [31:0] av, input logic [31:0] bv,
                            input logic cv, input logic sv);
        @(negedge clk);
        a     = av;
        b     = bv;
        cin   = cv;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        sub   = sv;
`else
        if (sv) $display("note: sub request ignored in this build");
`endif
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Counts busy cycles until done shows up; bounded.
    task automatic wait_done(input string tag, input int exp_busy);
        int nbusy;
        bit seen;
        nbusy = 0;
        seen  = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
            else if (busy) nbusy++;
        end
        chk({tag, "_done_seen"}, 64'(seen), 64'd1);
        chk({tag, "_busy_len"}, 64'(nbusy), 64'(exp_busy));
    endtask

    initial begin
        int nb;
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        cin   = 1'b0;
`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        sub   = 1'b0;
`endif
        repeat (2) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_s",    64'(s),    64'd0);
        chk("rst_cout", 64'(cout), 64'd0);
        rst = 1'b0;

        // 1: single carry into chunk 1
        do_start(32'h000000FF, 32'h00000001, 1'b0, 1'b0);
        wait_done("t1", 4);
        chk("t1_s",    64'(s),    64'h00000100);
        chk("t1_cout", 64'(cout), 64'd0);
        @(negedge clk);
        chk("t1_done_pulse", 64'(done), 64'd0);

        // 2: carry ripples through every chunk
        do_start(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0);
        wait_done("t2", 4);
        chk("t2_s",    64'(s),    64'h00000000);
        chk("t2_cout", 64'(cout), 64'd1);

        // 3: cin used, result held while idle
        do_start(32'h12345678, 32'h11111111, 1'b1, 1'b0);
        wait_done("t3", 4);
        chk("t3_s",    64'(s),    64'h2345678A);
        chk("t3_cout", 64'(cout), 64'd0);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t3_hold_s", 64'(s), 64'h2345678A);
        end
        chk("t3_idle_busy", 64'(busy), 64'd0);

        // 4: start re-pulses during ADD and DONE are ignored
        do_start(32'h00000001, 32'h00000001, 1'b0, 1'b0);
        @(negedge clk);
        a     = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        wait_done("t4", 3);
        a     = 32'hFFFFFFFF;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        nb = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (busy || done) nb++;
        end
        chk("t4_no_rerun", 64'(nb), 64'd0);
        chk("t4_s",    64'(s),    64'h00000002);
        chk("t4_cout", 64'(cout), 64'd0);

        // 5: asynchronous reset mid-ADD, between edges
        do_start(32'h11111111, 32'h22222222, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("t5_pre_busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1;
        chk("t5_rst_busy", 64'(busy), 64'd0);
        chk("t5_rst_done", 64'(done), 64'd0);
        chk("t5_rst_s",    64'(s),    64'd0);
        chk("t5_rst_cout", 64'(cout), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        do_start(32'h00000003, 32'h00000004, 1'b0, 1'b0);
        wait_done("t5", 4);
        chk("t5_s",    64'(s),    64'h00000007);
        chk("t5_cout", 64'(cout), 64'd0);

`ifdef MULTIWORD_ADD_SEQ_SUB_EN
        // 6: subtract mode
        do_start(32'h00000007, 32'h00000005, 1'b0, 1'b1);
        wait_done("t6a", 4);
        chk("t6a_s",    64'(s),    64'h00000002);
        chk("t6a_cout", 64'(cout), 64'd1);
        do_start(32'h00000005, 32'h00000007, 1'b0, 1'b1);
        wait_done("t6b", 4);
        chk("t6b_s",    64'(s),    64'hFFFFFFFE);
        chk("t6b_cout", 64'(cout), 64'd0);
        do_start(32'h00000005, 32'h00000007, 1'b0, 1'b0);
        wait_done("t6c", 4);
        chk("t6c_s",    64'(s),    64'h0000000C);
        chk("t6c_cout", 64'(cout), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
